// File: rtl/gpu_pkg.sv
// gpu_pkg: shared types and helpers for the GPU front end.
//   gp1_op_e          GP1 control opcodes (main_bus[31:24])
//   GPUSTAT_RESET     GPUSTAT value with everything at reset
//   mode_t            7-bit display mode register
//   hres_to_width     mode -> visible display width in pixels
//   vres_to_height    mode -> visible display height in lines
package gpu_pkg;

    typedef enum logic [7:0] {
        GP1_RESET     = 8'h00,
        GP1_FLUSH     = 8'h01,
        GP1_DISP_EN   = 8'h03,
        GP1_DISP_AREA = 8'h05,
        GP1_MODE      = 8'h08,
        GP1_INFO      = 8'h10
    } gp1_op_e;

    localparam logic [31:0] GPUSTAT_RESET = 32'h14802000;

    // Field order is MSB first, so the struct maps directly onto main_bus[6:0].
    typedef struct packed {
        logic       hres2;          // [6] forces 368-pixel width
        logic       vert_interlace; // [5]
        logic       color24;        // [4]
        logic       video_pal;      // [3]
        logic       vres;           // [2]
        logic [1:0] hres1;          // [1:0]
    } mode_t;

    function automatic logic [9:0] hres_to_width(input mode_t m);
        if (m.hres2) return 10'd368;
        case (m.hres1)
            2'd0:    return 10'd256;
            2'd1:    return 10'd320;
            2'd2:    return 10'd512;
            default: return 10'd640;
        endcase
    endfunction

    function automatic logic [9:0] vres_to_height(input mode_t m);
        return (m.vres && m.vert_interlace) ? 10'd480 : 10'd240;
    endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// gpu_cmd_fifo: synchronous FIFO with first-word fall-through from storage.
//   clk, rst     clock, synchronous active-high reset
//   flush        synchronous empty; wins over push/pop in the same cycle
//   push, wdata  write; dropped when full (full taken before any same-cycle pop)
//   pop          consume head; ignored when empty
//   rdata        head word, 0 when empty
//   full, empty, count   occupancy
module gpu_cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push, do_pop, clr;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign clr     = rst || flush;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= wdata;
    end

    // Pointers are AW bits wide, so wrap modulo DEPTH comes for free.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/gpu_frontend.sv
// gpu_frontend: CPU-facing GP0/GP1 front end of the GPU.
//   clk, rst            clock, synchronous active-high reset
//   gpu_en              gates all bus writes
//   to_gp0, to_gp1      write strobes for main_bus
//   main_bus            write data
//   gp0_pop             draw engine consumes gp0_data
//   gp0_data/valid      GP0 FIFO head
//   fifo_full, main_bus_rdy   backpressure
//   gpu_stat, gpu_read  GPUSTAT and GPUREAD
//   display_*           live display configuration
module gpu_frontend
    import gpu_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [31:0] GPU_VERSION = 32'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gpu_en,
    input  logic        to_gp0,
    input  logic        to_gp1,
    input  logic [31:0] main_bus,
    input  logic        gp0_pop,
    output logic [31:0] gp0_data,
    output logic        gp0_valid,
    output logic        fifo_full,
    output logic        main_bus_rdy,
    output logic [31:0] gpu_stat,
    output logic [31:0] gpu_read,
    output logic [9:0]  display_x,
    output logic [9:0]  display_y,
    output logic [9:0]  display_w,
    output logic [9:0]  display_h,
    output logic        display_color_mode,
    output logic        display_enable
);

    localparam int AW = $clog2(FIFO_DEPTH);

    mode_t       mode;
    gp1_op_e     op;
    logic        gp1_wr, full_reset, fifo_flush, fifo_empty;
    logic [AW:0] fifo_count;

    assign op         = gp1_op_e'(main_bus[31:24]);
    assign gp1_wr     = gpu_en && to_gp1;
    assign full_reset = rst || (gp1_wr && op == GP1_RESET);
    // Flush also covers a same-cycle GP0 push, so that word is discarded.
    assign fifo_flush = gp1_wr && (op == GP1_RESET || op == GP1_FLUSH);

    gpu_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fifo_flush),
        .push  (gpu_en && to_gp0),
        .pop   (gp0_pop),
        .wdata (main_bus),
        .rdata (gp0_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign gp0_valid    = !fifo_empty;
    assign main_bus_rdy = !fifo_full;

    always_ff @(posedge clk) begin
        if (full_reset) begin
            mode           <= '0;
            display_x      <= '0;
            display_y      <= '0;
            display_enable <= 1'b0;
            gpu_read       <= GPU_VERSION;
        end else if (gp1_wr) begin
            case (op)
                GP1_DISP_EN:   display_enable <= !main_bus[0];
                GP1_DISP_AREA: begin
                    display_x <= main_bus[9:0];
                    display_y <= {1'b0, main_bus[18:10]};
                end
                GP1_MODE:      mode <= mode_t'(main_bus[6:0]);
                GP1_INFO:      if (main_bus[2:0] == 3'd7) gpu_read <= GPU_VERSION;
                default:       ;
            endcase
        end
    end

    assign display_w          = hres_to_width(mode);
    assign display_h          = vres_to_height(mode);
    assign display_color_mode = mode.color24;

    always_comb begin
        gpu_stat        = '0;
        gpu_stat[28]    = !fifo_full;
        gpu_stat[26]    = !gp0_valid;
        gpu_stat[23]    = !display_enable;
        gpu_stat[22:17] = {mode.vert_interlace, mode.color24, mode.video_pal,
                           mode.vres, mode.hres1};
        gpu_stat[16]    = mode.hres2;
        gpu_stat[13]    = 1'b1;
    end

    // Bus bits no GP1 command decodes, plus occupancy kept for future status use.
    logic unused_bits;
    assign unused_bits = ^{main_bus[23:19], fifo_count};

endmodule

// File: tb/tb_gpu_frontend.sv
module tb_gpu_frontend;

    logic        clk = 1'b0;
    logic        rst, gpu_en, to_gp0, to_gp1, gp0_pop;
    logic [31:0] main_bus;
    logic [31:0] gp0_data, gpu_stat, gpu_read;
    logic        gp0_valid, fifo_full, main_bus_rdy, display_color_mode, display_enable;
    logic [9:0]  display_x, display_y, display_w, display_h;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    gpu_frontend #(.FIFO_DEPTH(16), .GPU_VERSION(32'd2)) dut (
        .clk(clk), .rst(rst), .gpu_en(gpu_en), .to_gp0(to_gp0), .to_gp1(to_gp1),
        .main_bus(main_bus), .gp0_pop(gp0_pop), .gp0_data(gp0_data),
        .gp0_valid(gp0_valid), .fifo_full(fifo_full), .main_bus_rdy(main_bus_rdy),
        .gpu_stat(gpu_stat), .gpu_read(gpu_read), .display_x(display_x),
        .display_y(display_y), .display_w(display_w), .display_h(display_h),
        .display_color_mode(display_color_mode), .display_enable(display_enable)
    );

    always #5 clk = ~clk;

    // Reference model state (what the DUT should hold after the latest edge).
    logic [31:0] mq[$];
    logic [31:0] exp_q[$];
    logic [6:0]  m_mode;
    int          m_x, m_y;
    bit          m_den;
    logic [31:0] m_read;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_mode = 0; m_x = 0; m_y = 0; m_den = 0; m_read = 2;
    endfunction

    function automatic int exp_w();
        int widths[4] = '{256, 320, 512, 640};
        if (m_mode[6]) return 368;
        return widths[m_mode[1:0]];
    endfunction

    function automatic int exp_h();
        return (m_mode[2] && m_mode[5]) ? 480 : 240;
    endfunction

    function automatic logic [31:0] exp_stat();
        logic [31:0] s;
        s = 32'h0000_2000;
        if (mq.size() != 16) s = s | 32'h1000_0000;
        if (mq.size() == 0)  s = s | 32'h0400_0000;
        if (!m_den)          s = s | 32'h0080_0000;
        s = s + (32'(m_mode[5:0]) * 32'h2_0000) + (32'(m_mode[6]) * 32'h1_0000);
        return s;
    endfunction

    function automatic void model_apply(input bit r, input bit en, input bit g0, input bit g1,
                                        input logic [31:0] bus, input bit pop);
        logic [7:0] op;
        bit full;
        if (r) begin model_reset(); return; end
        op   = bus[31:24];
        full = (mq.size() == 16);
        if (en && g1 && (op == 8'h00 || op == 8'h01)) begin
            if (op == 8'h00) model_reset();
            else mq.delete();
            return;
        end
        if (pop && mq.size() > 0) void'(mq.pop_front());
        if (en && g0 && !full) mq.push_back(bus);
        if (en && g1) begin
            case (op)
                8'h03: m_den = !bus[0];
                8'h05: begin m_x = int'(bus[9:0]); m_y = int'(bus[18:10]); end
                8'h08: m_mode = bus[6:0];
                8'h10: if (bus[2:0] == 3'd7) m_read = 2;
                default: ;
            endcase
        end
    endfunction

    task automatic step(input bit r, input bit en, input bit g0, input bit g1,
                        input logic [31:0] bus, input bit pop);
        rst = r; gpu_en = en; to_gp0 = g0; to_gp1 = g1; main_bus = bus; gp0_pop = pop;
        if (pop && mq.size() > 0) exp_q.push_back(mq[0]);
        @(posedge clk);
        model_apply(r, en, g0, g1, bus, pop);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands out a word, and
    // compares all status outputs against the model every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (gp0_pop && gp0_valid) begin
                if (exp_q.size() == 0) chk("unexpected_pop", gp0_data, 32'hxxxx_xxxx);
                else chk("gp0_data", gp0_data, exp_q.pop_front());
            end
            chk("gp0_valid", 32'(gp0_valid), 32'(mq.size() != 0));
            chk("fifo_full", 32'(fifo_full), 32'(mq.size() == 16));
            chk("main_bus_rdy", 32'(main_bus_rdy), 32'(mq.size() != 16));
            if (mq.size() == 0) chk("gp0_data_empty", gp0_data, 32'h0);
            chk("gpu_stat", gpu_stat, exp_stat());
            chk("gpu_read", gpu_read, m_read);
            chk("display_x", 32'(display_x), m_x);
            chk("display_y", 32'(display_y), m_y);
            chk("display_w", 32'(display_w), exp_w());
            chk("display_h", 32'(display_h), exp_h());
            chk("display_color", 32'(display_color_mode), 32'(m_mode[4]));
            chk("display_enable", 32'(display_enable), 32'(m_den));
        end
    end

    initial begin
        model_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        mon_en = 1;
        step(0, 1, 0, 0, 0, 0);
        chk("rst_stat", gpu_stat, 32'h14802000);
        chk("rst_read", gpu_read, 32'd2);

        // Fill, overflow, full push+pop, drain.
        for (int i = 0; i < 16; i++) step(0, 1, 1, 0, 32'hA000_0000 + 32'(i), 0);
        chk("full_flag", 32'(fifo_full), 32'd1);
        chk("stat28_full", 32'(gpu_stat[28]), 32'd0);
        step(0, 1, 1, 0, 32'hDEAD_0000, 0);
        step(0, 1, 1, 0, 32'hBEEF_0000, 1);
        chk("head_after_pp", gp0_data, 32'hA000_0001);
        chk("not_full_15", 32'(fifo_full), 32'd0);
        for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 0, 1);
        chk("stat26_empty", 32'(gpu_stat[26]), 32'd1);

        // gpu_en low gates everything.
        step(0, 0, 1, 1, 32'h0300_0000, 0);
        chk("gated", 32'(display_enable), 32'd0);

        step(0, 1, 0, 1, 32'h0800_0041, 0);
        chk("w368", 32'(display_w), 32'd368);
        chk("stat16", 32'(gpu_stat[16]), 32'd1);
        step(0, 1, 0, 1, 32'h0800_0027, 0);
        chk("w640", 32'(display_w), 32'd640);
        chk("h480", 32'(display_h), 32'd480);
        step(0, 1, 0, 1, 32'h0300_0000, 0);
        step(0, 1, 0, 1, 32'h0504_2814, 0);
        chk("den", 32'(display_enable), 32'd1);
        chk("dx", 32'(display_x), 32'h014);
        chk("dy", 32'(display_y), 32'h10A);

        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 32'h5000_0000 + 32'(i), 0);
        step(0, 1, 1, 1, 32'h0100_0000, 0);
        chk("flush_empty", 32'(gp0_valid), 32'd0);
        step(0, 1, 0, 1, 32'h1000_0007, 0);
        step(0, 1, 0, 1, 32'h0000_0000, 0);
        chk("gp1_reset_stat", gpu_stat, 32'h14802000);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0]  ops[8] = '{8'h00, 8'h01, 8'h03, 8'h05, 8'h08, 8'h10, 8'h02, 8'hFF};
            logic [7:0]  op;
            bit          r, g1;
            op = ops[$urandom_range(7)];
            if (op == 8'h00 || op == 8'h01) op = ($urandom_range(7) == 0) ? op : 8'h08;
            r  = ($urandom_range(299) == 0);
            g1 = ($urandom_range(5) == 0);
            step(r, $urandom_range(9) != 0, $urandom_range(1) == 1, g1,
                 {op, 24'($urandom)}, $urandom_range(2) == 0);
        end

        step(0, 1, 0, 0, 0, 0);
        mon_en = 0;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpu_frontend.md
# gpu_frontend

- CPU-facing command and status front end of the GPU; the generalised successor to the fixed-value GPU stub.
- Accepts GP0 words from the main bus into a parametrised command FIFO and exposes them to the rasteriser through a valid/pop interface.
- Decodes GP1 control writes into live display-configuration registers and builds GPUSTAT and GPUREAD from real state.
- Sits between the CPU bus decoder and the GPU draw/VRAM engine.

## Interface
Parameters:
- FIFO_DEPTH, 16, GP0 FIFO entries (power of two, ≥2)
- GPU_VERSION, 32'd2, value returned for GP1 info index 7

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- gpu_en  in  1  gates all bus writes; when low, to_gp0/to_gp1 are ignored
- to_gp0  in  1  write main_bus to GP0 this cycle
- to_gp1  in  1  write main_bus to GP1 this cycle
- main_bus  in  32  write data
- gp0_pop  in  1  draw engine consumes gp0_data
- gp0_data  out  32  FIFO head word
- gp0_valid  out  1  FIFO non-empty
- fifo_full  out  1  FIFO holds FIFO_DEPTH words
- main_bus_rdy  out  1  equals !fifo_full
- gpu_stat  out  32  GPUSTAT
- gpu_read  out  32  GPUREAD latch
- display_x, display_y, display_w, display_h  out  10 each  display area origin and size
- display_color_mode  out  1  1 = 24-bit display
- display_enable  out  1  1 = display on

## Operation
- GP0 push when gpu_en & to_gp0 & !fifo_full. A push while full is dropped silently; no state changes.
- Pop when gp0_pop & gp0_valid; a pop while empty is ignored.
- Simultaneous push and pop: both occur and the count is unchanged. When full, fifo_full is evaluated on the pre-pop count, so the push is dropped.
- GP1 opcode is main_bus[31:24]; all GP1 writes require gpu_en.
  - 0x00: full reset. All registers return to reset values and the FIFO is flushed.
  - 0x01: flush FIFO only.
  - 0x03: display_enable <= !main_bus[0].
  - 0x05: display_x <= main_bus[9:0]; display_y <= {1'b0, main_bus[18:10]}.
  - 0x08: mode register <= main_bus[6:0].
  - 0x10: if main_bus[2:0]==7, gpu_read <= GPU_VERSION; other indices leave gpu_read unchanged.
  - All other opcodes are ignored.
- display_w decode:
  - mode[6]=1 gives 368.
  - Otherwise mode[1:0] gives 0→256, 1→320, 2→512, 3→640.
- display_h = 480 when mode[2] & mode[5]; otherwise 240.
- display_color_mode = mode[4].
- GPUSTAT bits:
  - [28] = !fifo_full
  - [27] = 0
  - [26] = !gp0_valid
  - [23] = !display_enable
  - [22:17] = {mode[5], mode[4], mode[3], mode[2], mode[1:0]}
  - [16] = mode[6]
  - [13] = 1
  - all other bits = 0
- Same-cycle GP0 push and GP1 0x00/0x01: the flush wins and the pushed word is discarded.

## Timing
- Reset values: FIFO empty, gp0_valid=0, gp0_data=0, fifo_full=0, main_bus_rdy=1, mode=0 (display_w=256, display_h=240, display_color_mode=0), display_x=0, display_y=0, display_enable=0, gpu_read=GPU_VERSION, gpu_stat=32'h14802000.
- All register and FIFO updates take effect on the clock edge. Outputs reflect a write on the cycle after it.
- gpu_stat, fifo_full, main_bus_rdy and gp0_valid are combinational decodes of registered state; they have no extra cycle of latency.
- gp0_data is valid the cycle after the push into an empty FIFO (first-word fall-through from storage, not from main_bus).
- rst asserted mid-operation: same result as GP1 0x00. Any pushes, pops or writes in that cycle are discarded.
- Read and write pointers are log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH, with a separate count of width log2(FIFO_DEPTH)+1.

## Structure
- Shared package gpu_pkg:
  - GP1 opcode enum
  - GPUSTAT_RESET constant (32'h14802000)
  - mode register typedef (packed struct of the 7 mode bits)
  - functions hres_to_width and vres_to_height
- Sub-module gpu_cmd_fifo (parametrised depth/width, synchronous flush, push/pop/full/empty/count). Reusable later for the GPUREAD VRAM-readback FIFO.
- gpu_frontend itself holds the GP1 decoder, display registers and GPUSTAT assembly.

## Test plan
- Reset, then idle: gpu_stat=32'h14802000, display_enable=0, main_bus_rdy=1, gp0_valid=0, gpu_read=2.
- Push 16 GP0 words 0xA0000000+i (FIFO_DEPTH=16) → fifo_full=1 and gpu_stat[28]=0. Push a 17th word → dropped. Pop 16 → words come out in order and gpu_stat[26]=1.
- Full FIFO with simultaneous push+pop → count stays 15, the new word is absent, and the next head is the second original word.
- GP1 0x08000041 → display_w=368 and gpu_stat[16]=1. Then GP1 0x08000027 → display_w=640, display_h=480.
- GP1 0x03000000 then 0x05042814 → display_enable=1, gpu_stat[23]=0, display_x=0x014, display_y=0x10A.
- 5 GP0 words queued, then GP1 0x01000000 in the same cycle as a GP0 push → FIFO empty next cycle. Then GP1 0x10000007 → gpu_read=2, and GP1 0x00000000 → all outputs at reset values.
